// File: rtl/cmd_mem_loader.sv
// Command memory loader: packs a 32-bit word stream into 128-bit commands
// and writes them to consecutive command memory addresses from a base.
module cmd_mem_loader #(
   parameter int DATA_WIDTH     = 32,
   parameter int CMD_WIDTH      = 128,
   parameter int WORDS_PER_CMD  = 4,
   parameter int CMD_ADDR_WIDTH = 16
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      start,
   input  logic [CMD_ADDR_WIDTH-1:0] base_addr,
   input  logic [DATA_WIDTH-1:0]     in_data,
   input  logic                      in_valid,
   input  logic                      in_last,
   output logic                      in_ready,
   output logic [CMD_WIDTH-1:0]      cmd_write,
   output logic [CMD_ADDR_WIDTH-1:0] cmd_write_addr,
   output logic                      cmd_write_enable,
   output logic [CMD_ADDR_WIDTH:0]   cmd_count,
   output logic                      load_done,
   output logic                      overflow
);

   localparam int IDX_W = (WORDS_PER_CMD > 1) ? $clog2(WORDS_PER_CMD) : 1;
   localparam logic [IDX_W-1:0]          LAST_IDX  = IDX_W'(WORDS_PER_CMD - 1);
   localparam logic [CMD_ADDR_WIDTH-1:0] LAST_ADDR = '1;

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      DONE
   } state_t;

   state_t                    state;
   logic [CMD_ADDR_WIDTH-1:0] ptr;
   logic [IDX_W-1:0]          idx;
   logic [CMD_WIDTH-1:0]      pack;
   logic [CMD_WIDTH-1:0]      pack_next;
   logic                      accept;

   // in_ready is only ever high in LOAD, so a handshake implies LOAD.
   assign accept = in_valid && in_ready;

   // Pack buffer with the incoming word dropped into the current chunk slot.
   always_comb begin
      // NOTE: give every always_comb output a default first so no path leaves
      // it unassigned; an unassigned path infers a latch.
      pack_next = pack;
      for (int k = 0; k < WORDS_PER_CMD; k++) begin
         if (idx == IDX_W'(k)) begin
            pack_next[k*DATA_WIDTH +: DATA_WIDTH] = in_data;
         end
      end
   end

   // Load sequencer: state, packing, commit strobe, counters and flags.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values, independent of statement order.
      if (reset) begin
         state            <= IDLE;
         ptr              <= '0;
         idx              <= '0;
         pack             <= '0;
         in_ready         <= 1'b0;
         cmd_write        <= '0;
         cmd_write_addr   <= '0;
         cmd_write_enable <= 1'b0;
         cmd_count        <= '0;
         load_done        <= 1'b0;
         overflow         <= 1'b0;
      end else begin
         cmd_write_enable <= 1'b0;
         case (state)
            IDLE, DONE: begin
               if (start) begin
                  state     <= LOAD;
                  ptr       <= base_addr;
                  idx       <= '0;
                  pack      <= '0;
                  cmd_count <= '0;
                  load_done <= 1'b0;
                  overflow  <= 1'b0;
                  in_ready  <= 1'b1;
               end
            end
            LOAD: begin
               if (accept) begin
                  if (idx == LAST_IDX || in_last) begin
                     // Commit: unfilled chunks are already zero in pack.
                     cmd_write        <= pack_next;
                     cmd_write_addr   <= ptr;
                     cmd_write_enable <= 1'b1;
                     cmd_count        <= cmd_count + (CMD_ADDR_WIDTH+1)'(1);
                     ptr              <= ptr + CMD_ADDR_WIDTH'(1);
                     pack             <= '0;
                     idx              <= '0;
                     if (in_last) begin
                        state     <= DONE;
                        in_ready  <= 1'b0;
                        load_done <= 1'b1;
                     end else if (ptr == LAST_ADDR) begin
                        // Top of the address space: stop instead of wrapping.
                        state     <= DONE;
                        in_ready  <= 1'b0;
                        load_done <= 1'b1;
                        overflow  <= 1'b1;
                     end
                  end else begin
                     pack <= pack_next;
                     idx  <= idx + IDX_W'(1);
                  end
               end
            end
            default: begin
               state    <= IDLE;
               in_ready <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_cmd_mem_loader.sv
// Directed bench for cmd_mem_loader: a default-width instance for the main
// stream tests and a 4-bit-address instance for the overflow boundary.
module tb_cmd_mem_loader;

   typedef struct {
      logic [15:0]  addr;
      logic [127:0] data;
      int           cyc;
   } wr_t;

   typedef struct {
      logic [3:0]   addr;
      logic [127:0] data;
      logic         ovf;
   } swr_t;

   logic         clk = 1'b0;
   logic         reset;
   logic         start;
   logic [15:0]  base_addr;
   logic [31:0]  in_data;
   logic         in_valid;
   logic         in_last;
   logic         in_ready;
   logic [127:0] cmd_write;
   logic [15:0]  cmd_write_addr;
   logic         cmd_write_enable;
   logic [16:0]  cmd_count;
   logic         load_done;
   logic         overflow;

   logic         s_start;
   logic [3:0]   s_base;
   logic [31:0]  s_data;
   logic         s_valid;
   logic         s_last;
   logic         s_ready;
   logic [127:0] s_cmd;
   logic [3:0]   s_addr;
   logic         s_en;
   logic [4:0]   s_count;
   logic         s_done;
   logic         s_ovf;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;
   int hs_q[$];
   wr_t  wr_q[$];
   int   s_hs_cnt = 0;
   swr_t s_wr_q[$];

   cmd_mem_loader dut (
      .clk              (clk),
      .reset            (reset),
      .start            (start),
      .base_addr        (base_addr),
      .in_data          (in_data),
      .in_valid         (in_valid),
      .in_last          (in_last),
      .in_ready         (in_ready),
      .cmd_write        (cmd_write),
      .cmd_write_addr   (cmd_write_addr),
      .cmd_write_enable (cmd_write_enable),
      .cmd_count        (cmd_count),
      .load_done        (load_done),
      .overflow         (overflow)
   );

   cmd_mem_loader #(.CMD_ADDR_WIDTH(4)) dut_s (
      .clk              (clk),
      .reset            (reset),
      .start            (s_start),
      .base_addr        (s_base),
      .in_data          (s_data),
      .in_valid         (s_valid),
      .in_last          (s_last),
      .in_ready         (s_ready),
      .cmd_write        (s_cmd),
      .cmd_write_addr   (s_addr),
      .cmd_write_enable (s_en),
      .cmd_count        (s_count),
      .load_done        (s_done),
      .overflow         (s_ovf)
   );

   always #5 clk = ~clk;

   // Handshake log, stamped with the edge index at which it happened.
   always @(posedge clk) begin
      if (in_valid && in_ready) hs_q.push_back(cyc);
      if (s_valid && s_ready) s_hs_cnt++;
      cyc++;
   end

   // Write-port log, sampled mid-cycle.
   always @(negedge clk) begin
      if (cmd_write_enable) wr_q.push_back('{cmd_write_addr, cmd_write, cyc});
      if (s_en) s_wr_q.push_back('{s_addr, s_cmd, s_ovf});
   end

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_start(input logic [15:0] b);
      start     = 1'b1;
      base_addr = b;
      tick();
      start = 1'b0;
   endtask

   // Offer one word after `gap` idle cycles; wait (bounded) for the handshake.
   task automatic send(input logic [31:0] d, input logic last, input int gap);
      int n;
      bit ok;
      in_valid = 1'b0;
      repeat (gap) tick();
      in_valid = 1'b1;
      in_data  = d;
      in_last  = last;
      n  = hs_q.size();
      ok = 1'b0;
      for (int i = 0; i < 20 && !ok; i++) begin
         tick();
         ok = (hs_q.size() > n);
      end
      check($sformatf("accept_%0h", d), 128'(ok), 128'd1);
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   initial begin
      int gaps[12] = '{0, 1, 0, 2, 1, 0, 0, 1, 3, 0, 1, 0};
      reset = 1'b1; start = 1'b0; base_addr = '0; in_data = '0; in_valid = 1'b0; in_last = 1'b0;
      s_start = 1'b0; s_base = '0; s_data = '0; s_valid = 1'b0; s_last = 1'b0;
      repeat (3) tick();
      reset = 1'b0;

      // Reset state
      check("rst_ready", 128'(in_ready), 128'd0);
      check("rst_cmd", cmd_write, 128'd0);
      check("rst_addr", 128'(cmd_write_addr), 128'd0);
      check("rst_en", 128'(cmd_write_enable), 128'd0);
      check("rst_count", 128'(cmd_count), 128'd0);
      check("rst_done", 128'(load_done), 128'd0);
      check("rst_ovf", 128'(overflow), 128'd0);

      // Two full commands back-to-back, last on chunk 3
      do_start(16'h0010);
      check("t1_ready_after_start", 128'(in_ready), 128'd1);
      for (int i = 0; i < 8; i++) send(32'(i), i == 7, 0);
      tick();
      check("t1_nwr", 128'(wr_q.size()), 128'd2);
      check("t1_addr0", 128'(wr_q[0].addr), 128'h0010);
      check("t1_data0", wr_q[0].data, 128'h00000003_00000002_00000001_00000000);
      check("t1_addr1", 128'(wr_q[1].addr), 128'h0011);
      check("t1_data1", wr_q[1].data, 128'h00000007_00000006_00000005_00000004);
      check("t1_spacing", 128'(wr_q[1].cyc - wr_q[0].cyc), 128'd4);
      check("t1_lat", 128'(wr_q[0].cyc - hs_q[3]), 128'd1);
      check("t1_count", 128'(cmd_count), 128'd2);
      check("t1_done", 128'(load_done), 128'd1);
      check("t1_ready", 128'(in_ready), 128'd0);
      check("t1_ovf", 128'(overflow), 128'd0);

      // Partial final command, zero padded
      wr_q.delete(); hs_q.delete();
      do_start(16'h0000);
      check("t2_done_cleared", 128'(load_done), 128'd0);
      check("t2_count_cleared", 128'(cmd_count), 128'd0);
      for (int i = 0; i < 6; i++) send(32'hA0 + 32'(i), i == 5, 0);
      repeat (3) tick();
      check("t2_nwr", 128'(wr_q.size()), 128'd2);
      check("t2_data0", wr_q[0].data, 128'h000000A3_000000A2_000000A1_000000A0);
      check("t2_addr1", 128'(wr_q[1].addr), 128'h0001);
      check("t2_data1", wr_q[1].data, 128'h00000000_00000000_000000A5_000000A4);
      check("t2_count", 128'(cmd_count), 128'd2);
      check("t2_hold_cmd", cmd_write, 128'h00000000_00000000_000000A5_000000A4);
      check("t2_hold_addr", 128'(cmd_write_addr), 128'h0001);
      check("t2_en_low", 128'(cmd_write_enable), 128'd0);

      // Valid gaps over 12 words
      wr_q.delete(); hs_q.delete();
      do_start(16'h0020);
      for (int i = 0; i < 12; i++) send(32'h100 + 32'(i), i == 11, gaps[i]);
      tick();
      check("t3_nwr", 128'(wr_q.size()), 128'd3);
      check("t3_data0", wr_q[0].data, 128'h00000103_00000102_00000101_00000100);
      check("t3_addr2", 128'(wr_q[2].addr), 128'h0022);
      check("t3_data2", wr_q[2].data, 128'h0000010B_0000010A_00000109_00000108);
      for (int k = 0; k < 3; k++)
         check($sformatf("t3_lat%0d", k), 128'(wr_q[k].cyc - hs_q[4*k+3]), 128'd1);
      check("t3_count", 128'(cmd_count), 128'd3);

      // Reset mid-command
      wr_q.delete(); hs_q.delete();
      do_start(16'h0030);
      send(32'hDEAD0000, 1'b0, 0);
      send(32'hDEAD0001, 1'b0, 0);
      reset = 1'b1;
      tick();
      check("t5_nwr", 128'(wr_q.size()), 128'd0);
      check("t5_ready", 128'(in_ready), 128'd0);
      check("t5_cmd", cmd_write, 128'd0);
      check("t5_en", 128'(cmd_write_enable), 128'd0);
      check("t5_count", 128'(cmd_count), 128'd0);
      reset = 1'b0;
      tick();
      do_start(16'h0040);
      for (int i = 0; i < 4; i++) send(32'hB0 + 32'(i), 1'b0, 0);
      tick();
      check("t5_nwr_new", 128'(wr_q.size()), 128'd1);
      check("t5_addr_new", 128'(wr_q[0].addr), 128'h0040);
      check("t5_data_new", wr_q[0].data, 128'h000000B3_000000B2_000000B1_000000B0);

      // start mid-LOAD is ignored
      send(32'hC0, 1'b0, 0);
      send(32'hC1, 1'b0, 0);
      do_start(16'h0099);
      check("t6_ready", 128'(in_ready), 128'd1);
      check("t6_count", 128'(cmd_count), 128'd1);
      send(32'hC2, 1'b0, 0);
      send(32'hC3, 1'b1, 0);
      tick();
      check("t6_nwr", 128'(wr_q.size()), 128'd2);
      check("t6_addr", 128'(wr_q[1].addr), 128'h0041);
      check("t6_data", wr_q[1].data, 128'h000000C3_000000C2_000000C1_000000C0);
      check("t6_count_end", 128'(cmd_count), 128'd2);

      // Overflow at top of a 4-bit address space
      s_start = 1'b1; s_base = 4'hE;
      tick();
      s_start = 1'b0;
      s_valid = 1'b1;
      for (int i = 0; i < 30; i++) begin
         s_data = 32'(s_hs_cnt);
         tick();
      end
      s_valid = 1'b0;
      check("ov_consumed", 128'(s_hs_cnt), 128'd8);
      check("ov_nwr", 128'(s_wr_q.size()), 128'd2);
      check("ov_addr0", 128'(s_wr_q[0].addr), 128'hE);
      check("ov_data0", s_wr_q[0].data, 128'h00000003_00000002_00000001_00000000);
      check("ov_flag0", 128'(s_wr_q[0].ovf), 128'd0);
      check("ov_addr1", 128'(s_wr_q[1].addr), 128'hF);
      check("ov_data1", s_wr_q[1].data, 128'h00000007_00000006_00000005_00000004);
      check("ov_flag_commit", 128'(s_wr_q[1].ovf), 128'd1);
      check("ov_flag", 128'(s_ovf), 128'd1);
      check("ov_done", 128'(s_done), 128'd1);
      check("ov_ready", 128'(s_ready), 128'd0);
      check("ov_count", 128'(s_count), 128'd2);
      s_start = 1'b1; s_base = 4'h2;
      tick();
      s_start = 1'b0;
      check("ov_restart_clear", 128'(s_ovf), 128'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/cmd_mem_loader.md
Name: cmd_mem_loader

Overview:
- Upstream stage of the processor command memory: accepts a 32-bit word stream (host/DMA/testbench) and packs every 4 words into one 128-bit command.
- Drives the command memory write port (cmd_write, cmd_write_addr, cmd_write_enable) at consecutive addresses starting from a programmed base.
- Handles partial final commands (zero-padded), reports completion, and reports address-space overflow.

Parameters:
- DATA_WIDTH, 32, width of one input word (= one memory chunk)
- CMD_WIDTH, 128, command width; must equal WORDS_PER_CMD*DATA_WIDTH
- WORDS_PER_CMD, 4, words packed per command
- CMD_ADDR_WIDTH, 16, command memory address width

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- start  input  1  single-cycle pulse; begins a load at base_addr
- base_addr  input  CMD_ADDR_WIDTH  first command address, sampled on start
- in_data  input  DATA_WIDTH  stream word; first word of a command goes to bits [31:0]
- in_valid  input  1  in_data valid
- in_last  input  1  marks the final word of the load
- in_ready  output  1  loader can accept a word
- cmd_write  output  CMD_WIDTH  packed command
- cmd_write_addr  output  CMD_ADDR_WIDTH  target address
- cmd_write_enable  output  1  single-cycle write strobe
- cmd_count  output  CMD_ADDR_WIDTH+1  commands written since last start
- load_done  output  1  level; load finished
- overflow  output  1  sticky; words arrived past the last address

Behaviour:
- One clock; reset is synchronous and active-high. All state and outputs are registered.
- Reset values: state=IDLE, in_ready=0, cmd_write=0, cmd_write_addr=0, cmd_write_enable=0, cmd_count=0, load_done=0, overflow=0, pack buffer and chunk index = 0.
- Word transfer occurs only when in_valid && in_ready. in_data/in_last are ignored otherwise.
- States:
  - IDLE: in_ready=0. start -> LOAD.
  - LOAD: in_ready=1.
  - DONE: in_ready=0, load_done=1. start -> LOAD.
- On start (IDLE or DONE):
  - address pointer <= base_addr; chunk index <= 0; pack buffer <= 0.
  - cmd_count <= 0; load_done <= 0; overflow <= 0.
  - in_ready goes to 1 on the next cycle.
- start in LOAD is ignored.
- Packing: the word accepted at chunk index k is written into pack bits [DATA_WIDTH*(k+1)-1 : DATA_WIDTH*k]; the index then increments.
- Commit: accepting chunk WORDS_PER_CMD-1, or any word with in_last=1, in cycle N produces the following in cycle N+1:
  - cmd_write = packed buffer including that word, with unfilled chunks = 0.
  - cmd_write_addr = current pointer; cmd_write_enable = 1 for exactly that cycle.
  - cmd_count increments in that same cycle.
  - Pointer increments; pack buffer and index clear.
- cmd_write and cmd_write_addr hold their values when enable=0.
- Throughput: in_ready stays 1 across commits in LOAD; one word/cycle sustained, so back-to-back commits every 4 cycles.
- in_last handling:
  - When committing due to in_last, the state goes to DONE in cycle N+1; in_ready=0 from cycle N+1.
  - in_last on chunk 3 yields one normal (full) commit, not two.
- Overflow: a commit to address 2^CMD_ADDR_WIDTH-1 without in_last moves to DONE with overflow=1 in the commit cycle. No wrap to address 0 and no further writes occur. With in_last on that commit, overflow=0.
- Words with in_valid while in_ready=0 are not consumed (upstream holds them).
- Reset asserted mid-load aborts the load: no write strobe is issued for a partially packed command, and all outputs return to reset values the next cycle.
- Zero-word load: start then no words leaves the block in LOAD indefinitely; there is no timeout.

Test Plan:
- Reset, start with base_addr=0x0010, stream 8 words 0x00000000..0x00000007 back-to-back, in_last on word 7 -> writes addr 0x0010 data 0x00000003_00000002_00000001_00000000, then addr 0x0011 data 0x00000007_00000006_00000005_00000004; strobes exactly 4 cycles apart; cmd_count=2; load_done=1; in_ready=0.
- Start base 0x0000, send 6 words 0xA0..0xA5, last on 0xA5 -> addr 0x0001 data 0x00000000_00000000_000000A5_000000A4; cmd_count=2.
- Random in_valid gaps (about 50% duty) over 12 words -> identical write sequence as the gapless case; each strobe exactly 1 cycle after the 4th word's handshake.
- CMD_ADDR_WIDTH=4, base 0xE, 16 words with no last -> writes at 0xE and 0xF only, then overflow=1, load_done=1, in_ready=0; words 9+ not consumed; no write to 0x0.
- Assert reset after 2 words of a command -> no cmd_write_enable; next cycle all outputs at reset values; a new start plus 4 words writes correct data at the new base.
- start pulsed mid-LOAD -> ignored: pointer and cmd_count are unchanged and writes continue sequentially.
